// File: rtl/comp_mode_sched.sv
// ============================================================================
//  Module   : comp_mode_sched
//  Purpose  : Block-level output scheduler for the SR/ZRL/BPC compressor.
//             Waits for a size entry from all three encoders, selects the
//             winning mode, and emits a fixed BEATS-beat frame carrying the
//             winner's data followed by zero padding. Losing encoders' data
//             beats are popped and discarded to keep all FIFOs block-aligned.
//  Ports    : clk, rst_n (async, active-low)
//             sr/zrl/bpc size FIFO heads + empties, size_rd_o (pops all three)
//             sr/zrl/bpc data FIFO heads + empties, *_d_rd_o pops
//             data_o/valid_o/ready_i/sop_o/eop_o/mode_o output frame stream
//  Optional : COMP_MODE_SCHED_STATS_EN adds cnt_sr_o, cnt_zrl_o, cnt_bpc_o
//             (frames per mode) and pad_beats_o (accepted padding beats).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module comp_mode_sched #(
  parameter int DATA_W = 64,
  parameter int SIZE_W = 11,
  parameter int BEATS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sr_s_data_i,
  input  logic              sr_s_empty_i,
  input  logic [SIZE_W-1:0] zrl_s_data_i,
  input  logic              zrl_s_empty_i,
  input  logic [SIZE_W-1:0] bpc_s_data_i,
  input  logic              bpc_s_empty_i,
  output logic              size_rd_o,
  input  logic [DATA_W-1:0] sr_d_data_i,
  input  logic              sr_d_empty_i,
  output logic              sr_d_rd_o,
  input  logic [DATA_W-1:0] zrl_d_data_i,
  input  logic              zrl_d_empty_i,
  output logic              zrl_d_rd_o,
  input  logic [DATA_W-1:0] bpc_d_data_i,
  input  logic              bpc_d_empty_i,
  output logic              bpc_d_rd_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              sop_o,
  output logic              eop_o,
  output logic [1:0]        mode_o
`ifdef COMP_MODE_SCHED_STATS_EN
  ,
  output logic [31:0]       cnt_sr_o,
  output logic [31:0]       cnt_zrl_o,
  output logic [31:0]       cnt_bpc_o,
  output logic [31:0]       pad_beats_o
`endif
);

  localparam int SHIFT = $clog2(DATA_W);
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam int K_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [31:0]      LIMIT  = 32'(BEATS * DATA_W);
  localparam logic [CNT_W-1:0] NB_MAX = CNT_W'(BEATS);
  localparam logic [K_W-1:0]   K_LAST = K_W'(BEATS - 1);

  localparam logic [1:0] MODE_SR  = 2'b01;
  localparam logic [1:0] MODE_ZRL = 2'b10;
  localparam logic [1:0] MODE_BPC = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t           state;
  logic [K_W-1:0]   k;
  logic [CNT_W-1:0] nb_zrl;
  logic [CNT_W-1:0] nb_bpc;

  // Number of DATA_W beats covering s bits, saturated at BEATS. Sizes above
  // LIMIT therefore saturate, which also covers the BPC fallback case.
  function automatic logic [CNT_W-1:0] calc_nb(input logic [SIZE_W-1:0] s);
    logic [SIZE_W:0] q;
    q = {1'b0, s >> SHIFT} + {{SIZE_W{1'b0}}, |s[SHIFT-1:0]};
    if (q >= (SIZE_W+1)'(BEATS)) return NB_MAX;
    return q[CNT_W-1:0];
  endfunction

  // Mode decision from the size FIFO heads; only consumed in LOAD.
  logic       zrl_fit;
  logic       bpc_fit;
  logic [1:0] dec_mode;

  always_comb begin
    zrl_fit  = 32'(zrl_s_data_i) <= LIMIT;
    bpc_fit  = 32'(bpc_s_data_i) <= LIMIT;
    dec_mode = MODE_BPC;
    if (!sr_s_data_i)
      dec_mode = MODE_SR;
    else if (zrl_fit && (!bpc_fit || (zrl_s_data_i <= bpc_s_data_i)))
      dec_mode = MODE_ZRL;
  end

  // Per-beat requirement: an encoder participates while k < its beat count.
  // SR always supplies a full frame of beats.
  logic [CNT_W-1:0] k_ext;
  logic             in_send;
  logic             req_zrl;
  logic             req_bpc;
  logic             req_sel;
  logic             accept;

  always_comb begin
    k_ext   = CNT_W'(k);
    in_send = (state == SEND);
    req_zrl = k_ext < nb_zrl;
    req_bpc = k_ext < nb_bpc;
    case (mode_o)
      MODE_SR:  req_sel = 1'b1;
      MODE_ZRL: req_sel = req_zrl;
      default:  req_sel = req_bpc;
    endcase
  end

  // Handshake outputs are decoded from registered state so that a FIFO going
  // empty mid-frame stalls the beat in the same cycle without a lookahead.
  assign valid_o    = in_send && !sr_d_empty_i
                      && (!req_zrl || !zrl_d_empty_i)
                      && (!req_bpc || !bpc_d_empty_i);
  assign accept     = valid_o && ready_i;
  assign sr_d_rd_o  = accept;
  assign zrl_d_rd_o = accept && req_zrl;
  assign bpc_d_rd_o = accept && req_bpc;
  assign size_rd_o  = (state == LOAD);
  assign sop_o      = valid_o && (k == '0);
  assign eop_o      = valid_o && (k == K_LAST);

  always_comb begin
    data_o = '0;
    if (valid_o && req_sel) begin
      case (mode_o)
        MODE_SR:  data_o = sr_d_data_i;
        MODE_ZRL: data_o = zrl_d_data_i;
        default:  data_o = bpc_d_data_i;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      k      <= '0;
      mode_o <= 2'b00;
      nb_zrl <= '0;
      nb_bpc <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!sr_s_empty_i && !zrl_s_empty_i && !bpc_s_empty_i)
            state <= LOAD;
        end
        LOAD: begin
          mode_o <= dec_mode;
          nb_zrl <= calc_nb(zrl_s_data_i);
          nb_bpc <= calc_nb(bpc_s_data_i);
          k      <= '0;
          state  <= SEND;
        end
        SEND: begin
          if (accept) begin
            if (k == K_LAST) begin
              k     <= '0;
              state <= IDLE;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef COMP_MODE_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_sr_o    <= '0;
      cnt_zrl_o   <= '0;
      cnt_bpc_o   <= '0;
      pad_beats_o <= '0;
    end else if (accept) begin
      if (k == K_LAST) begin
        case (mode_o)
          MODE_SR:  cnt_sr_o  <= cnt_sr_o + 32'd1;
          MODE_ZRL: cnt_zrl_o <= cnt_zrl_o + 32'd1;
          default:  cnt_bpc_o <= cnt_bpc_o + 32'd1;
        endcase
      end
      if (!req_sel)
        pad_beats_o <= pad_beats_o + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_comp_mode_sched.sv
// ============================================================================
//  Module   : tb_comp_mode_sched
//  Purpose  : Self-checking bench for comp_mode_sched. Models the six
//             show-ahead FIFOs as queues and scores every accepted beat
//             against an expected-beat queue filled when a block is queued.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_comp_mode_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sr_s_data_i, sr_s_empty_i;
  logic [10:0] zrl_s_data_i, bpc_s_data_i;
  logic        zrl_s_empty_i, bpc_s_empty_i;
  logic        size_rd_o;
  logic [63:0] sr_d_data_i, zrl_d_data_i, bpc_d_data_i;
  logic        sr_d_empty_i, zrl_d_empty_i, bpc_d_empty_i;
  logic        sr_d_rd_o, zrl_d_rd_o, bpc_d_rd_o;
  logic [63:0] data_o;
  logic        valid_o, ready_i, sop_o, eop_o;
  logic [1:0]  mode_o;
`ifdef COMP_MODE_SCHED_STATS_EN
  logic [31:0] cnt_sr_o, cnt_zrl_o, cnt_bpc_o, pad_beats_o;
`endif

  always #5 clk = ~clk;

  comp_mode_sched #(.DATA_W(64), .SIZE_W(11), .BEATS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .sr_s_data_i(sr_s_data_i), .sr_s_empty_i(sr_s_empty_i),
    .zrl_s_data_i(zrl_s_data_i), .zrl_s_empty_i(zrl_s_empty_i),
    .bpc_s_data_i(bpc_s_data_i), .bpc_s_empty_i(bpc_s_empty_i),
    .size_rd_o(size_rd_o),
    .sr_d_data_i(sr_d_data_i), .sr_d_empty_i(sr_d_empty_i), .sr_d_rd_o(sr_d_rd_o),
    .zrl_d_data_i(zrl_d_data_i), .zrl_d_empty_i(zrl_d_empty_i), .zrl_d_rd_o(zrl_d_rd_o),
    .bpc_d_data_i(bpc_d_data_i), .bpc_d_empty_i(bpc_d_empty_i), .bpc_d_rd_o(bpc_d_rd_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .sop_o(sop_o), .eop_o(eop_o), .mode_o(mode_o)
`ifdef COMP_MODE_SCHED_STATS_EN
    , .cnt_sr_o(cnt_sr_o), .cnt_zrl_o(cnt_zrl_o), .cnt_bpc_o(cnt_bpc_o)
    , .pad_beats_o(pad_beats_o)
`endif
  );

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  mode;
  } beat_t;

  bit          sr_sq[$];
  logic [10:0] zrl_sq[$], bpc_sq[$];
  logic [63:0] sr_dq[$], zrl_dq[$], bpc_dq[$];
  beat_t       exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int accepted, pops_sr, pops_zrl, pops_bpc, pops_size;
  int force_cnt = 0;
  int stall_at  = -1;
  int cyc, first_acc, last_acc;
  bit toggle = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic refresh();
    sr_s_empty_i  = (sr_sq.size() == 0);
    sr_s_data_i   = sr_s_empty_i ? 1'b0 : sr_sq[0];
    zrl_s_empty_i = (zrl_sq.size() == 0);
    zrl_s_data_i  = zrl_s_empty_i ? 11'd0 : zrl_sq[0];
    bpc_s_empty_i = (bpc_sq.size() == 0);
    bpc_s_data_i  = bpc_s_empty_i ? 11'd0 : bpc_sq[0];
    sr_d_empty_i  = (sr_dq.size() == 0);
    sr_d_data_i   = sr_d_empty_i ? 64'd0 : sr_dq[0];
    zrl_d_empty_i = (zrl_dq.size() == 0);
    zrl_d_data_i  = zrl_d_empty_i ? 64'd0 : zrl_dq[0];
    bpc_d_empty_i = (bpc_dq.size() == 0) || (force_cnt > 0);
    bpc_d_data_i  = (bpc_dq.size() == 0) ? 64'd0 : bpc_dq[0];
  endtask

  // One clock: sample outputs at negedge, apply FIFO pops just after posedge.
  task automatic step();
    beat_t e;
    bit do_sr, do_zrl, do_bpc, do_size;
    @(negedge clk);
    cyc++;
    if (valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", data_o, e.data);
        check("beat_sop", 64'(sop_o), 64'(e.sop));
        check("beat_eop", 64'(eop_o), 64'(e.eop));
        check("beat_mode", 64'(mode_o), 64'(e.mode));
      end
      if (accepted == 0) first_acc = cyc;
      last_acc = cyc;
      accepted++;
    end
    if (!valid_o) check("idle_data", data_o, 64'd0);
    if (force_cnt > 0) check("stall_valid", 64'(valid_o), 64'd0);
    do_sr = sr_d_rd_o; do_zrl = zrl_d_rd_o; do_bpc = bpc_d_rd_o; do_size = size_rd_o;
    @(posedge clk);
    #1;
    if (do_sr)  begin pops_sr++;  if (sr_dq.size()  > 0) void'(sr_dq.pop_front());  end
    if (do_zrl) begin pops_zrl++; if (zrl_dq.size() > 0) void'(zrl_dq.pop_front()); end
    if (do_bpc) begin pops_bpc++; if (bpc_dq.size() > 0) void'(bpc_dq.pop_front()); end
    if (do_size) begin
      pops_size++;
      if (sr_sq.size()  > 0) void'(sr_sq.pop_front());
      if (zrl_sq.size() > 0) void'(zrl_sq.pop_front());
      if (bpc_sq.size() > 0) void'(bpc_sq.pop_front());
    end
    if (force_cnt > 0) force_cnt--;
    if (stall_at >= 0 && accepted == stall_at) begin
      force_cnt = 3;
      stall_at  = -1;
    end
    ready_i = toggle ? ~ready_i : 1'b1;
    refresh();
  endtask

  // Queue one block and its expected frame; enz/enb are the expected ZRL/BPC
  // beat counts and em the expected mode, all taken from hand calculation.
  task automatic run_frame(input bit flag, input int zs, input int bs,
                           input logic [1:0] em, input int enz, input int enb,
                           input bit tog, input int stall, input int stop_at);
    logic [63:0] srd[8], zd[8], bd[8];
    beat_t e;
    int nsel;
    sr_sq.push_back(flag);
    zrl_sq.push_back(11'(zs));
    bpc_sq.push_back(11'(bs));
    for (int i = 0; i < 8; i++) begin
      srd[i] = {$urandom, $urandom};
      zd[i]  = {$urandom, $urandom};
      bd[i]  = {$urandom, $urandom};
      sr_dq.push_back(srd[i]);
      if (i < enz) zrl_dq.push_back(zd[i]);
      if (i < enb) bpc_dq.push_back(bd[i]);
    end
    nsel = (em == 2'b01) ? 8 : (em == 2'b10) ? enz : enb;
    for (int i = 0; i < 8; i++) begin
      if (i >= nsel)       e.data = 64'd0;
      else if (em == 2'b01) e.data = srd[i];
      else if (em == 2'b10) e.data = zd[i];
      else                 e.data = bd[i];
      e.sop  = (i == 0);
      e.eop  = (i == 7);
      e.mode = em;
      exp_q.push_back(e);
    end
    accepted = 0; pops_sr = 0; pops_zrl = 0; pops_bpc = 0; pops_size = 0;
    cyc = 0; first_acc = 0; last_acc = 0;
    toggle = tog; stall_at = stall; ready_i = 1'b1;
    refresh();
    while (accepted < 8 && cyc < 400 && !(stop_at >= 0 && accepted == stop_at))
      step();
    if (stop_at < 0) begin
      check("frame_beats", 64'(accepted), 64'd8);
      check("pops_sr", 64'(pops_sr), 64'd8);
      check("pops_zrl", 64'(pops_zrl), 64'(enz));
      check("pops_bpc", 64'(pops_bpc), 64'(enb));
      check("pops_size", 64'(pops_size), 64'd1);
      if (!tog && stall < 0) check("no_bubble", 64'(last_acc - first_acc + 1), 64'd8);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(valid_o), 64'd0);
    check({tag, "_sop_eop"}, 64'({sop_o, eop_o}), 64'd0);
    check({tag, "_rd"}, 64'({size_rd_o, sr_d_rd_o, zrl_d_rd_o, bpc_d_rd_o}), 64'd0);
    check({tag, "_data"}, data_o, 64'd0);
    check({tag, "_mode"}, 64'(mode_o), 64'd0);
  endtask

  initial begin
    ready_i = 1'b1;
    refresh();
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check("idle_valid", 64'(valid_o), 64'd0);

    run_frame(1'b0, 100, 300, 2'b01, 2, 5, 1'b0, -1, -1);   // SR wins
    run_frame(1'b1, 130, 130, 2'b10, 3, 3, 1'b0, -1, -1);   // tie -> ZRL
    run_frame(1'b1, 600, 513, 2'b11, 8, 8, 1'b0, -1, -1);   // fallback BPC
    run_frame(1'b1, 0,   64,  2'b10, 0, 1, 1'b0, -1, -1);   // zero-size ZRL
    run_frame(1'b1, 600, 513, 2'b11, 8, 8, 1'b1, 2, -1);    // ready toggle + stall
    run_frame(1'b1, 300, 200, 2'b11, 5, 4, 1'b0, -1, -1);   // BPC smaller
    run_frame(1'b1, 512, 512, 2'b10, 8, 8, 1'b0, -1, -1);   // both at limit
    run_frame(1'b1, 513, 512, 2'b11, 8, 8, 1'b0, -1, -1);   // ZRL just over

    // Reset in the middle of a frame, after four accepted beats.
    run_frame(1'b0, 100, 300, 2'b01, 2, 5, 1'b0, -1, 4);
    check("pre_reset_beats", 64'(accepted), 64'd4);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    sr_sq.delete(); zrl_sq.delete(); bpc_sq.delete();
    sr_dq.delete(); zrl_dq.delete(); bpc_dq.delete();
    exp_q.delete();
    force_cnt = 0; toggle = 1'b0; ready_i = 1'b1;
    refresh();
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_frame(1'b1, 130, 130, 2'b10, 3, 3, 1'b0, -1, -1);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
